// File: rtl/panel_pkg.sv
// Shared types and helpers for the front-panel display driver:
// glyph codes, converter states, page encodings and the segment encoder.
package panel_pkg;

    typedef logic [3:0] glyph_t;

    localparam glyph_t DIG_DASH  = 4'hE;
    localparam glyph_t DIG_BLANK = 4'hF;

    localparam logic [1:0] PAGE_FUNDS  = 2'd0;
    localparam logic [1:0] PAGE_BET    = 2'd1;
    localparam logic [1:0] PAGE_WHEELS = 2'd2;
    localparam logic [1:0] PAGE_BLANK  = 2'd3;

    // Largest value that still fits in eight decimal digits.
    localparam logic [31:0] MAX_DECIMAL = 32'd99_999_999;

    typedef enum logic [1:0] {
        LOAD,
        SHIFT,
        COMMIT
    } conv_state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_encode(input glyph_t g);
        logic [6:0] code;
        case (g)
            4'd0:     code = 7'b1000000;
            4'd1:     code = 7'b1111001;
            4'd2:     code = 7'b0100100;
            4'd3:     code = 7'b0110000;
            4'd4:     code = 7'b0011001;
            4'd5:     code = 7'b0010010;
            4'd6:     code = 7'b0000010;
            4'd7:     code = 7'b1111000;
            4'd8:     code = 7'b0000000;
            4'd9:     code = 7'b0010000;
            DIG_DASH: code = 7'b0111111;
            default:  code = 7'b1111111;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one input bit per clock,
// 32 shifts per conversion, done is high during the final shift cycle.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] bin_in,
    output logic [31:0] bcd,
    output logic        done
);

    logic [31:0] bin_q;
    logic [31:0] bcd_q;
    logic [31:0] bcd_adj;
    logic [4:0]  bit_cnt;
    logic        busy;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
        end else if (start) begin
            bin_q   <= bin_in;
            bcd_q   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            {bcd_q, bin_q} <= {bcd_adj[30:0], bin_q, 1'b0};
            bit_cnt        <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) begin
                busy <= 1'b0;
            end
        end
    end

    assign done = busy && (bit_cnt == 5'd31);
    assign bcd  = bcd_q;

endmodule

// File: rtl/panel_display_driver.sv
// Multiplexed 8-digit 7-segment front-panel driver for the slot machine:
// snapshots the selected page, converts it to BCD, and scans the digits.
module panel_display_driver #(
    parameter int CLK_DIV = 16,
    parameter int NDIG    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     displayfunds,
    input  logic [31:0]     displaybet,
    input  logic [2:0]      displaywheel0,
    input  logic [2:0]      displaywheel1,
    input  logic [2:0]      displaywheel2,
    input  logic [2:0]      displaydice,
    input  logic [1:0]      pagesel,
    output logic [NDIG-1:0] an,
    output logic [6:0]      seg,
    output logic            convbusy
);

    import panel_pkg::*;

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = $clog2(NDIG);

    conv_state_t      state;
    conv_state_t      next_state;
    logic             conv_start;
    logic             conv_done;
    logic             commit;
    logic [31:0]      bcd;
    logic [31:0]      src_value;

    logic [1:0]       snap_page;
    logic             snap_over;
    logic [2:0]       snap_w0;
    logic [2:0]       snap_w1;
    logic [2:0]       snap_w2;
    logic [2:0]       snap_dice;

    glyph_t           glyphs     [NDIG];
    glyph_t           glyph_next [NDIG];
    logic             lit;

    logic [DIV_W-1:0] div;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        conv_start = 1'b0;
        commit     = 1'b0;
        case (state)
            LOAD: begin
                conv_start = 1'b1;
                next_state = SHIFT;
            end
            SHIFT: begin
                if (conv_done) begin
                    next_state = COMMIT;
                end
            end
            COMMIT: begin
                commit     = 1'b1;
                next_state = LOAD;
            end
            default: next_state = LOAD;
        endcase
    end

    // Registered so it reads 0 during reset and tracks the state after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            convbusy <= 1'b0;
        end else begin
            convbusy <= (next_state != COMMIT);
        end
    end

    always_comb begin
        case (pagesel)
            PAGE_FUNDS: src_value = displayfunds;
            PAGE_BET:   src_value = displaybet;
            default:    src_value = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_page <= PAGE_BLANK;
            snap_over <= 1'b0;
            snap_w0   <= '0;
            snap_w1   <= '0;
            snap_w2   <= '0;
            snap_dice <= '0;
        end else if (conv_start) begin
            snap_page <= pagesel;
            snap_over <= (src_value > MAX_DECIMAL);
            snap_w0   <= displaywheel0;
            snap_w1   <= displaywheel1;
            snap_w2   <= displaywheel2;
            snap_dice <= displaydice;
        end
    end

    bin2bcd_seq u_conv (
        .clk    (clk),
        .rst    (rst),
        .start  (conv_start),
        .bin_in (src_value),
        .bcd    (bcd),
        .done   (conv_done)
    );

    // Leading zeros stay blank until the first nonzero digit; digit 0 always shows.
    always_comb begin
        lit = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            glyph_next[i] = DIG_BLANK;
        end
        case (snap_page)
            PAGE_FUNDS, PAGE_BET: begin
                if (snap_over) begin
                    for (int i = 0; i < NDIG; i++) begin
                        glyph_next[i] = DIG_DASH;
                    end
                end else begin
                    for (int i = NDIG - 1; i >= 0; i--) begin
                        if ((bcd[4*i +: 4] != 4'd0) || (i == 0)) begin
                            lit = 1'b1;
                        end
                        if (lit) begin
                            glyph_next[i] = bcd[4*i +: 4];
                        end
                    end
                end
            end
            PAGE_WHEELS: begin
                glyph_next[6] = {1'b0, snap_w0};
                glyph_next[5] = {1'b0, snap_w1};
                glyph_next[4] = {1'b0, snap_w2};
                glyph_next[0] = (snap_dice == 3'd0) ? DIG_BLANK : {1'b0, snap_dice};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NDIG; i++) begin
                glyphs[i] <= DIG_BLANK;
            end
        end else if (commit) begin
            for (int i = 0; i < NDIG; i++) begin
                glyphs[i] <= glyph_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_W'(CLK_DIV - 1)) begin
            div <= '0;
            idx <= (idx == IDX_W'(NDIG - 1)) ? '0 : idx + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Outputs re-register every cycle so a commit shows up mid-slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= '1;
            seg <= 7'h7F;
        end else begin
            an  <= ~({{(NDIG - 1){1'b0}}, 1'b1} << idx);
            seg <= seg_encode(glyphs[idx]);
        end
    end

endmodule

// File: tb/tb_panel_display_driver.sv
// Scoreboard bench for panel_display_driver: expected panel frames are queued
// when a page is driven and compared against a captured scan after a commit.
module tb_panel_display_driver;

    localparam int CLK_DIV = 4;

    typedef logic [7:0][6:0] frame_t;

    logic        clk;
    logic        rst;
    logic [31:0] displayfunds;
    logic [31:0] displaybet;
    logic [2:0]  displaywheel0;
    logic [2:0]  displaywheel1;
    logic [2:0]  displaywheel2;
    logic [2:0]  displaydice;
    logic [1:0]  pagesel;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        convbusy;

    frame_t exp_q[$];
    int     checks = 0;
    int     passes = 0;

    panel_display_driver #(.CLK_DIV(CLK_DIV), .NDIG(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .displayfunds  (displayfunds),
        .displaybet    (displaybet),
        .displaywheel0 (displaywheel0),
        .displaywheel1 (displaywheel1),
        .displaywheel2 (displaywheel2),
        .displaydice   (displaydice),
        .pagesel       (pagesel),
        .an            (an),
        .seg           (seg),
        .convbusy      (convbusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int g);
        case (g)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            14: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic frame_t build_num_frame(input logic [31:0] v);
        frame_t          f;
        int              d [8];
        longint unsigned t;
        bit              shown;
        t     = v;
        shown = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d[i] = int'(t % 10);
            t    = t / 10;
        end
        for (int i = 7; i >= 0; i--) begin
            if (v > 32'd99_999_999) begin
                f[i] = ref_seg(14);
            end else begin
                if (d[i] != 0 || i == 0) shown = 1'b1;
                f[i] = shown ? ref_seg(d[i]) : 7'h7F;
            end
        end
        return f;
    endfunction

    function automatic frame_t build_wheel_frame(input int w0, input int w1, input int w2, input int dice);
        frame_t f;
        for (int i = 0; i < 8; i++) f[i] = 7'h7F;
        f[6] = ref_seg(w0);
        f[5] = ref_seg(w1);
        f[4] = ref_seg(w2);
        f[0] = (dice == 0) ? 7'h7F : ref_seg(dice);
        return f;
    endfunction

    task automatic applyStimulus(input logic [1:0] page, input logic [31:0] funds, input logic [31:0] bet,
                                 input logic [2:0] w0, input logic [2:0] w1, input logic [2:0] w2,
                                 input logic [2:0] dice);
        frame_t f;
        @(negedge clk);
        pagesel       = page;
        displayfunds  = funds;
        displaybet    = bet;
        displaywheel0 = w0;
        displaywheel1 = w1;
        displaywheel2 = w2;
        displaydice   = dice;
        case (page)
            2'd0:    f = build_num_frame(funds);
            2'd1:    f = build_num_frame(bet);
            2'd2:    f = build_wheel_frame(int'(w0), int'(w1), int'(w2), int'(dice));
            default: for (int i = 0; i < 8; i++) f[i] = 7'h7F;
        endcase
        exp_q.push_back(f);
    endtask

    // Returns at a negedge inside a COMMIT cycle.
    task automatic wait_commit();
        int n;
        n = 0;
        @(negedge clk);
        while (convbusy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (convbusy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (convbusy !== 1'b0) checkOutput("commit_wait", {31'd0, convbusy}, 32'd0);
    endtask

    task automatic capture_compare(input string name);
        frame_t     obs;
        frame_t     exp;
        logic [7:0] seen;
        logic [7:0] onehot;
        for (int i = 0; i < 8; i++) obs[i] = 7'h7F;
        seen = 8'h00;
        @(posedge clk);
        @(posedge clk);
        repeat (32) begin
            @(negedge clk);
            for (int d = 0; d < 8; d++) begin
                onehot = ~(8'b1 << d);
                if (an === onehot) begin
                    obs[d]  = seg;
                    seen[d] = 1'b1;
                end
            end
        end
        checkOutput({name, "_cover"}, {24'd0, seen}, 32'h0000_00FF);
        if (exp_q.size() == 0) begin
            checkOutput({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            for (int d = 0; d < 8; d++) begin
                checkOutput($sformatf("%s_d%0d", name, d), {25'd0, obs[d]}, {25'd0, exp[d]});
            end
        end
    endtask

    task automatic run_frame(input string name);
        wait_commit();
        wait_commit();
        capture_compare(name);
    endtask

    task automatic check_scan_timing();
        logic [7:0] prev;
        logic [7:0] exp_an;
        int         n;
        int         cnt;
        n    = 0;
        prev = an;
        @(negedge clk);
        while (!(an === 8'hFE && prev !== 8'hFE) && n < 64) begin
            prev = an;
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 8; k++) begin
            exp_an = ~(8'b1 << k);
            checkOutput($sformatf("an_seq%0d", k), {24'd0, an}, {24'd0, exp_an});
            cnt = 0;
            while (an === exp_an && cnt < 20) begin
                cnt++;
                @(negedge clk);
            end
            checkOutput($sformatf("an_hold%0d", k), cnt, CLK_DIV);
        end
        checkOutput("an_wrap", {24'd0, an}, 32'h0000_00FE);
    endtask

    initial begin
        int n;
        rst           = 1'b0;
        displayfunds  = $urandom();
        displaybet    = $urandom();
        displaywheel0 = 3'($urandom_range(0, 7));
        displaywheel1 = 3'($urandom_range(0, 7));
        displaywheel2 = 3'($urandom_range(0, 7));
        displaydice   = 3'($urandom_range(0, 6));
        pagesel       = 2'($urandom_range(0, 3));

        repeat (5) begin
            @(negedge clk);
            checkOutput("rst_an", {24'd0, an}, 32'h0000_00FF);
            checkOutput("rst_seg", {25'd0, seg}, 32'h0000_007F);
            checkOutput("rst_busy", {31'd0, convbusy}, 32'd0);
            displayfunds = $urandom();
            displaybet   = $urandom();
            pagesel      = 2'($urandom_range(0, 3));
        end

        applyStimulus(2'd0, 32'd1234, 32'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        rst = 1'b1;
        n   = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (convbusy !== 1'b0 && n < 100);
        checkOutput("first_commit", n, 33);
        capture_compare("funds1234");
        check_scan_timing();

        n = 0;
        while (an !== 8'hF7 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checkOutput("d3_an", {24'd0, an}, 32'h0000_00F7);
        checkOutput("d3_seg", {25'd0, seg}, {25'd0, 7'b1111001});
        #1 rst = 1'b0;
        #1;
        checkOutput("async_an", {24'd0, an}, 32'h0000_00FF);
        checkOutput("async_seg", {25'd0, seg}, 32'h0000_007F);
        checkOutput("async_busy", {31'd0, convbusy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(2'd1, 32'd5, 32'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        run_frame("bet0");
        applyStimulus(2'd1, 32'd5, 32'd100_000_000, 3'd0, 3'd0, 3'd0, 3'd0);
        run_frame("bet_over");
        applyStimulus(2'd1, 32'd5, 32'd99_999_999, 3'd0, 3'd0, 3'd0, 3'd0);
        run_frame("bet_max");

        applyStimulus(2'd2, 32'd5, 32'd0, 3'd3, 3'd3, 3'd3, 3'd0);
        run_frame("wheels_d0");
        applyStimulus(2'd2, 32'd5, 32'd0, 3'd3, 3'd3, 3'd3, 3'd5);
        run_frame("wheels_d5");
        applyStimulus(2'd2, 32'd5, 32'd0, 3'd7, 3'd0, 3'd1, 3'd6);
        run_frame("wheels_mix");

        applyStimulus(2'd3, 32'd1234, 32'd1234, 3'd1, 3'd2, 3'd3, 3'd4);
        run_frame("page3");

        applyStimulus(2'd0, 32'd7, 32'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        run_frame("funds7");
        wait_commit();
        repeat (12) @(negedge clk);
        exp_q.push_back(build_num_frame(32'd7));
        applyStimulus(2'd0, 32'd99_999_999, 32'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        wait_commit();
        capture_compare("midpass_old");
        wait_commit();
        capture_compare("midpass_new");

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
